w_stimulus_gen: RTL

Serial pattern transmitter that produces the `w` bit stream consumed by the one-hot and binary sequence detectors, plus a cycle-aligned expected-`z` prediction for self-checking. Loads a parallel pattern (up to MAX_LEN bits) on a start pulse and shifts it out LSB-first, optionally repeated. Emission can advance freely or be gated by a step enable, for debounced button stepping on the board. It sits in front of the detectors in the board top; `w` and `z_exp` drive the detector input and a compare LED.

---
 rtl/w_stimulus_gen_pkg.sv | 17 +
 rtl/w_stimulus_gen_if.sv | 28 ++
 rtl/w_stimulus_gen_run_tracker.sv | 44 ++++
 rtl/w_stimulus_gen.sv | 104 ++++++++++
 4 files changed

// File: rtl/w_stimulus_gen_pkg.sv
// Shared types and sizing helpers for the w stimulus generator.
package w_stim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

  localparam int unsigned MAX_LEN_DEF = 16;

  // Width needed to hold a length value in 0..max_len.
  function automatic int unsigned len_w(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/w_stimulus_gen_if.sv
// Control/stream bundle between the stimulus generator and its user.
interface w_stim_if
  import w_stim_pkg::*;
#(
  parameter int unsigned MAX_LEN = MAX_LEN_DEF,
  parameter int unsigned LEN_W   = len_w(MAX_LEN)
);
  logic               start;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic [3:0]         repeat_n;
  logic               step_en;
  logic               w;
  logic               w_valid;
  logic               busy;
  logic               done;
  logic               z_exp;

  modport master (
    output start, pattern, len, repeat_n, step_en,
    input  w, w_valid, busy, done, z_exp
  );

  modport slave (
    input  start, pattern, len, repeat_n, step_en,
    output w, w_valid, busy, done, z_exp
  );
endinterface

// File: rtl/w_stimulus_gen_run_tracker.sv
// Golden "last two accepted bits equal" tracker; usable beside the detectors.
module run_tracker (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic accept,
  input  logic bit_in,
  output logic z_exp
);
  logic prev_q, prev_d;
  logic have_q, have_d;
  logic z_q,    z_d;

  // History update: clear wins, otherwise record the accepted bit.
  always_comb begin
    prev_d = prev_q;
    have_d = have_q;
    z_d    = z_q;
    if (clear) begin
      prev_d = 1'b0;
      have_d = 1'b0;
      z_d    = 1'b0;
    end else if (accept) begin
      z_d    = have_q & (prev_q == bit_in);
      prev_d = bit_in;
      have_d = 1'b1;
    end
  end

  // History registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q <= 1'b0;
      have_q <= 1'b0;
      z_q    <= 1'b0;
    end else begin
      prev_q <= prev_d;
      have_q <= have_d;
      z_q    <= z_d;
    end
  end

  assign z_exp = z_q;
endmodule

// File: rtl/w_stimulus_gen.sv
// Serial LSB-first pattern transmitter with repeat, step gating and z prediction.
module w_stimulus_gen
  import w_stim_pkg::*;
#(
  parameter int unsigned MAX_LEN = MAX_LEN_DEF,
  parameter int unsigned LEN_W   = len_w(MAX_LEN)
) (
  input logic     clk,
  input logic     reset,
  w_stim_if.slave bus
);
  state_e             state_q,    state_d;
  logic [MAX_LEN-1:0] pattern_q,  pattern_d;
  logic [LEN_W-1:0]   len_q,      len_d;
  logic [3:0]         repeat_q,   repeat_d;
  logic [LEN_W-1:0]   bit_idx_q,  bit_idx_d;
  logic [3:0]         pass_cnt_q, pass_cnt_d;
  logic               clear;
  logic               accept;
  logic               cur_bit;
  logic [MAX_LEN-1:0] sel_mask;

  // One-hot select mask keeps the bit pick free of index-width mismatches.
  assign sel_mask = MAX_LEN'(1) << bit_idx_q;
  assign cur_bit  = |(pattern_q & sel_mask);

  // Next-state, latch and bit/pass counter logic.
  always_comb begin
    state_d    = state_q;
    pattern_d  = pattern_q;
    len_d      = len_q;
    repeat_d   = repeat_q;
    bit_idx_d  = bit_idx_q;
    pass_cnt_d = pass_cnt_q;
    clear      = 1'b0;
    accept     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          clear = 1'b1;
          if (bus.len == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d    = ST_SHIFT;
            pattern_d  = bus.pattern;
            len_d      = (bus.len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.len;
            repeat_d   = bus.repeat_n;
            bit_idx_d  = '0;
            pass_cnt_d = '0;
          end
        end
      end
      ST_SHIFT: begin
        if (bus.step_en) begin
          accept = 1'b1;
          if (bit_idx_q != len_q - LEN_W'(1)) begin
            bit_idx_d = bit_idx_q + LEN_W'(1);
          end else if (pass_cnt_q != repeat_q) begin
            bit_idx_d  = '0;
            pass_cnt_d = pass_cnt_q + 4'd1;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      pattern_q  <= '0;
      len_q      <= '0;
      repeat_q   <= '0;
      bit_idx_q  <= '0;
      pass_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pattern_q  <= pattern_d;
      len_q      <= len_d;
      repeat_q   <= repeat_d;
      bit_idx_q  <= bit_idx_d;
      pass_cnt_q <= pass_cnt_d;
    end
  end

  run_tracker u_run_tracker (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .accept (accept),
    .bit_in (cur_bit),
    .z_exp  (bus.z_exp)
  );

  // Outputs decode from registered state, so reset clears them immediately.
  assign bus.w       = (state_q == ST_SHIFT) & cur_bit;
  assign bus.w_valid = (state_q == ST_SHIFT);
  assign bus.busy    = (state_q == ST_SHIFT);
  assign bus.done    = (state_q == ST_DONE);
endmodule
